// File: rtl/som_pkg.sv
// som_pkg: shared types and helpers for the SOM training sequencer.
//   - state_t    : sequencer FSM state encoding
//   - ADDR_W_DEF : default RAM address width
//   - LR_W_DEF   : default learning-rate width
//   - lr_decay   : one epoch step of the learning-rate schedule, floored at lr_min
package som_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int LR_W_DEF   = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT_DP = 3'd2,
      S_NEXT    = 3'd3,
      S_WB      = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // lr - (lr >> shift) never underflows, so only the floor needs care.
   function automatic logic [31:0] lr_decay(input logic [31:0] lr_cur,
                                            input logic [31:0] lr_min,
                                            input logic [31:0] shift);
      logic [31:0] dec;
      dec = lr_cur - (lr_cur >> shift);
      return (dec < lr_min) ? lr_min : dec;
   endfunction

endpackage

// File: rtl/som_decay.sv
// som_decay: registered learning rate and neighbourhood radius.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_init   : load LR_INIT / R_INIT (start of training)
//   step        : apply one epoch decay (lr floored at LR_MIN, radius saturating at 0)
//   lr, radius  : current values
module som_decay
   import som_pkg::*;
#(
   parameter int LR_W     = LR_W_DEF,
   parameter int R_W      = 3,
   parameter int LR_INIT  = 128,
   parameter int LR_MIN   = 8,
   parameter int LR_SHIFT = 2,
   parameter int R_INIT   = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_init,
   input  logic            step,
   output logic [LR_W-1:0] lr,
   output logic [R_W-1:0]  radius
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr     <= '0;
         radius <= '0;
      end else if (load_init) begin
         lr     <= LR_W'(LR_INIT);
         radius <= R_W'(R_INIT);
      end else if (step) begin
         lr     <= LR_W'(lr_decay(32'(lr), 32'(LR_MIN), 32'(LR_SHIFT)));
         radius <= (radius == '0) ? '0 : radius - R_W'(1);
      end
   end

endmodule

// File: rtl/som_train_sequencer.sv
// som_train_sequencer: multi-epoch SOM training scheduler.
// Streams VEC_LEN-word vectors from the image RAM, waits for the datapath
// (dp_done) after each vector, decays lr/radius at epoch boundaries and finally
// sweeps N_NEURON weight writes to RAM_W.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin training / return to IDLE
//   dp_done             : datapath finished the current vector
//   RAM_IF_A, RAM_IF_OE : image RAM read address / output enable
//   pix_valid           : image RAM data valid (OE delayed one cycle)
//   vec_valid           : pulse with the last word of a vector
//   lr, radius, epoch   : current training schedule values
//   RAM_W_A, RAM_W_WE   : weight write address / write enable
//   busy, done          : status
module som_train_sequencer
   import som_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int VEC_LEN  = 4,
   parameter int N_VEC    = 10240,
   parameter int N_EPOCH  = 4,
   parameter int N_NEURON = 64,
   parameter int LR_W     = LR_W_DEF,
   parameter int LR_INIT  = 128,
   parameter int LR_MIN   = 8,
   parameter int LR_SHIFT = 2,
   parameter int R_W      = 3,
   parameter int R_INIT   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              dp_done,
   output logic [ADDR_W-1:0] RAM_IF_A,
   output logic              RAM_IF_OE,
   output logic              pix_valid,
   output logic              vec_valid,
   output logic [LR_W-1:0]   lr,
   output logic [R_W-1:0]    radius,
   output logic [7:0]        epoch,
   output logic [ADDR_W-1:0] RAM_W_A,
   output logic              RAM_W_WE,
   output logic              busy,
   output logic              done
);

   localparam int WORD_W = (VEC_LEN  > 1) ? $clog2(VEC_LEN)  : 1;
   localparam int VEC_W  = (N_VEC    > 1) ? $clog2(N_VEC)    : 1;
   localparam int NRN_W  = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic [WORD_W-1:0]   word;
   logic [VEC_W-1:0]    vec;
   logic [NRN_W-1:0]    wb_cnt;
   logic                load, step;
   logic                word_last, vec_last, epoch_last, wb_last;

   assign word_last  = (word   == WORD_W'(VEC_LEN - 1));
   assign vec_last   = (vec    == VEC_W'(N_VEC - 1));
   assign epoch_last = (epoch  == 8'(N_EPOCH - 1));
   assign wb_last    = (wb_cnt == NRN_W'(N_NEURON - 1));

   assign RAM_IF_A = addr;
   assign RAM_W_A  = ADDR_W'(wb_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // abort has priority over every transition, including start in IDLE/DONE.
   always_comb begin
      state_nxt = state;
      RAM_IF_OE = 1'b0;
      RAM_W_WE  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               load      = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            busy      = 1'b1;
            RAM_IF_OE = 1'b1;
            if (abort)          state_nxt = S_IDLE;
            else if (word_last) state_nxt = S_WAIT_DP;
         end
         S_WAIT_DP: begin
            busy = 1'b1;
            if (abort)        state_nxt = S_IDLE;
            else if (dp_done) state_nxt = S_NEXT;
         end
         S_NEXT: begin
            busy = 1'b1;
            if (abort)            state_nxt = S_IDLE;
            else if (!vec_last)   state_nxt = S_FETCH;
            else if (!epoch_last) begin
               step      = 1'b1;
               state_nxt = S_FETCH;
            end else              state_nxt = S_WB;
         end
         S_WB: begin
            busy     = 1'b1;
            RAM_W_WE = 1'b1;
            if (abort)        state_nxt = S_IDLE;
            else if (wb_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (abort) state_nxt = S_IDLE;
            else if (start) begin
               load      = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The address only advances between words of a vector and in NEXT, so it
   // holds the last fetched word through WAIT_DP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         word      <= '0;
         vec       <= '0;
         epoch     <= '0;
         wb_cnt    <= '0;
         pix_valid <= 1'b0;
         vec_valid <= 1'b0;
      end else begin
         pix_valid <= RAM_IF_OE & ~abort;
         vec_valid <= (state == S_FETCH) & word_last & ~abort;
         if (load) begin
            addr   <= '0;
            word   <= '0;
            vec    <= '0;
            epoch  <= '0;
            wb_cnt <= '0;
         end else if (!abort) begin
            case (state)
               S_FETCH: begin
                  if (word_last) word <= '0;
                  else begin
                     word <= word + WORD_W'(1);
                     addr <= addr + ADDR_W'(1);
                  end
               end
               S_NEXT: begin
                  if (!vec_last) begin
                     vec  <= vec + VEC_W'(1);
                     addr <= addr + ADDR_W'(1);
                  end else if (!epoch_last) begin
                     epoch <= epoch + 8'd1;
                     vec   <= '0;
                     addr  <= '0;
                  end
               end
               S_WB: begin
                  if (!wb_last) wb_cnt <= wb_cnt + NRN_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

   som_decay #(
      .LR_W    (LR_W),
      .R_W     (R_W),
      .LR_INIT (LR_INIT),
      .LR_MIN  (LR_MIN),
      .LR_SHIFT(LR_SHIFT),
      .R_INIT  (R_INIT)
   ) u_decay (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_init(load),
      .step     (step),
      .lr       (lr),
      .radius   (radius)
   );

endmodule

// File: tb/tb_som_train_sequencer.sv
// tb_som_train_sequencer: randomized bench for som_train_sequencer with a
// queue-based reference schedule, plus a second instance exercising the lr floor.
module tb_som_train_sequencer;

   localparam int ADDR_W   = 18;
   localparam int VEC_LEN  = 4;
   localparam int N_VEC    = 4;
   localparam int N_EPOCH  = 3;
   localparam int N_NEURON = 8;
   localparam int LR_W     = 8;
   localparam int LR_INIT  = 128;
   localparam int LR_MIN   = 8;
   localparam int LR_SHIFT = 2;
   localparam int R_W      = 3;
   localparam int R_INIT   = 3;
   localparam int N_EPOCH2 = 5;
   localparam int LR_INIT2 = 10;

   logic clk = 1'b0;
   logic rst_n, start, abort, dp_done;
   logic [ADDR_W-1:0] ram_if_a, ram_w_a;
   logic              ram_if_oe, pix_valid, vec_valid, ram_w_we, busy, done;
   logic [LR_W-1:0]   lr;
   logic [R_W-1:0]    radius;
   logic [7:0]        epoch;

   logic start2, abort2, dp_done2;
   logic [ADDR_W-1:0] ram_if_a2, ram_w_a2;
   logic              ram_if_oe2, pix_valid2, vec_valid2, ram_w_we2, busy2, done2;
   logic [LR_W-1:0]   lr2;
   logic [R_W-1:0]    radius2;
   logic [7:0]        epoch2;

   always #5 clk = ~clk;

   som_train_sequencer #(
      .ADDR_W(ADDR_W), .VEC_LEN(VEC_LEN), .N_VEC(N_VEC), .N_EPOCH(N_EPOCH),
      .N_NEURON(N_NEURON), .LR_W(LR_W), .LR_INIT(LR_INIT), .LR_MIN(LR_MIN),
      .LR_SHIFT(LR_SHIFT), .R_W(R_W), .R_INIT(R_INIT)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dp_done(dp_done),
      .RAM_IF_A(ram_if_a), .RAM_IF_OE(ram_if_oe), .pix_valid(pix_valid),
      .vec_valid(vec_valid), .lr(lr), .radius(radius), .epoch(epoch),
      .RAM_W_A(ram_w_a), .RAM_W_WE(ram_w_we), .busy(busy), .done(done)
   );

   som_train_sequencer #(
      .ADDR_W(ADDR_W), .VEC_LEN(VEC_LEN), .N_VEC(1), .N_EPOCH(N_EPOCH2),
      .N_NEURON(2), .LR_W(LR_W), .LR_INIT(LR_INIT2), .LR_MIN(LR_MIN),
      .LR_SHIFT(LR_SHIFT), .R_W(R_W), .R_INIT(R_INIT)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .dp_done(dp_done2),
      .RAM_IF_A(ram_if_a2), .RAM_IF_OE(ram_if_oe2), .pix_valid(pix_valid2),
      .vec_valid(vec_valid2), .lr(lr2), .radius(radius2), .epoch(epoch2),
      .RAM_W_A(ram_w_a2), .RAM_W_WE(ram_w_we2), .busy(busy2), .done(done2)
   );

   typedef struct {
      int addr;
      int lr;
      int rad;
      int ep;
   } rd_t;

   rd_t exp_rd[$];
   int  exp_wr[$];
   int  final_lr, final_rad;
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk_eq(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int model_decay(input int l);
      int d;
      d = l - l / (1 << LR_SHIFT);
      return (d < LR_MIN) ? LR_MIN : d;
   endfunction

   function automatic longint all_outs();
      return {ram_if_a, ram_if_oe, pix_valid, vec_valid, lr, radius, epoch,
              ram_w_a, ram_w_we, busy, done};
   endfunction

   // Expected read stream: every epoch walks addresses 0..N_VEC*VEC_LEN-1
   // with that epoch's lr/radius; afterwards neurons 0..N_NEURON-1 are written.
   task automatic build_model();
      int l, r;
      exp_rd.delete();
      exp_wr.delete();
      l = LR_INIT;
      r = R_INIT;
      for (int e = 0; e < N_EPOCH; e++) begin
         for (int a = 0; a < N_VEC * VEC_LEN; a++) exp_rd.push_back('{a, l, r, e});
         final_lr  = l;
         final_rad = r;
         l = model_decay(l);
         r = (r > 0) ? r - 1 : 0;
      end
      for (int n = 0; n < N_NEURON; n++) exp_wr.push_back(n);
   endtask

   // Called just after a negedge with the DUT in IDLE or DONE.
   task automatic run_train(input int abort_ep, input bit rnd);
      int  due = -1;
      bit  prev_oe = 1'b0;
      int  last_addr = 0;
      int  oe_cnt = 0;
      int  vv_cnt = 0;
      rd_t x;
      build_model();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         chk_eq("pix_valid", pix_valid, prev_oe);
         chk_eq("vec_valid", vec_valid, prev_oe && !ram_if_oe);
         if (ram_if_oe) begin
            oe_cnt++;
            if (exp_rd.size() == 0) chk_eq("oe_extra", 1, 0);
            else begin
               x = exp_rd.pop_front();
               chk_eq("rd_addr", ram_if_a, x.addr);
               chk_eq("rd_lr", lr, x.lr);
               chk_eq("rd_radius", radius, x.rad);
               chk_eq("rd_epoch", epoch, x.ep);
               last_addr = x.addr;
            end
         end else if (busy && !ram_w_we) begin
            chk_eq("addr_hold", ram_if_a, last_addr);
         end
         if (ram_w_we) begin
            if (exp_wr.size() == 0) chk_eq("we_extra", 1, 0);
            else chk_eq("wr_addr", ram_w_a, exp_wr.pop_front());
         end
         if (vec_valid) begin
            vv_cnt++;
            if (abort_ep >= 0 && int'(epoch) == abort_ep) begin
               abort   = 1'b1;
               dp_done = 1'b0;
               start   = 1'b0;
               @(negedge clk);
               abort = 1'b0;
               chk_eq("abort_busy", busy, 0);
               chk_eq("abort_done", done, 0);
               chk_eq("abort_oe", ram_if_oe, 0);
               chk_eq("abort_pix", pix_valid, 0);
               chk_eq("abort_we", ram_w_we, 0);
               @(negedge clk);
               chk_eq("abort_idle_busy", busy, 0);
               chk_eq("abort_idle_oe", ram_if_oe, 0);
               return;
            end
            due = cyc + (rnd ? int'($urandom_range(1, 8)) : 5);
         end
         if (done) begin
            dp_done = 1'b0;
            start   = 1'b0;
            chk_eq("done_busy", busy, 0);
            chk_eq("done_oe", ram_if_oe, 0);
            chk_eq("done_we", ram_w_we, 0);
            chk_eq("final_lr", lr, final_lr);
            chk_eq("final_radius", radius, final_rad);
            chk_eq("final_epoch", epoch, N_EPOCH - 1);
            chk_eq("oe_cycles", oe_cnt, N_EPOCH * N_VEC * VEC_LEN);
            chk_eq("vec_pulses", vv_cnt, N_EPOCH * N_VEC);
            chk_eq("rd_left", exp_rd.size(), 0);
            chk_eq("wr_left", exp_wr.size(), 0);
            return;
         end
         prev_oe = ram_if_oe;
         // Spurious dp_done during FETCH and start while busy must be ignored.
         dp_done = (cyc == due) || (rnd && ram_if_oe && ($urandom_range(0, 3) == 0));
         start   = busy && rnd && ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      dp_done = 1'b0;
      start   = 1'b0;
      chk_eq("run_timeout", 0, 1);
   endtask

   initial begin
      int k;
      int l2, r2;
      int wr2;
      bit prev2;
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      dp_done  = 1'b0;
      start2   = 1'b0;
      abort2   = 1'b0;
      dp_done2 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk_eq("reset_outs", all_outs(), 0);
      end

      run_train(-1, 1'b0);   // fixed 5-cycle datapath latency
      run_train(-1, 1'b1);   // restart from DONE, randomized
      run_train(1, 1'b1);    // abort in epoch 1 WAIT_DP
      run_train(-1, 1'b1);   // fresh run after abort

      // Asynchronous reset in the middle of FETCH.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk_eq("mid_fetch_oe", ram_if_oe, 1);
      #2 rst_n = 1'b0;
      #1 chk_eq("async_reset_outs", all_outs(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("post_reset_outs", all_outs(), 0);

      // lr floor / radius saturation with LR_INIT=10, N_EPOCH=5.
      l2    = LR_INIT2;
      r2    = R_INIT;
      k     = 0;
      wr2   = 0;
      prev2 = 1'b0;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int cyc = 0; cyc < 500 && !done2; cyc++) begin
         if (ram_if_oe2 && !prev2) begin
            chk_eq("floor_lr", lr2, l2);
            chk_eq("floor_radius", radius2, r2);
            chk_eq("floor_epoch", epoch2, k);
            chk_eq("floor_addr0", ram_if_a2, 0);
            k++;
            l2 = model_decay(l2);
            r2 = (r2 > 0) ? r2 - 1 : 0;
         end
         if (vec_valid2) chk_eq("floor_vec_pix", pix_valid2, 1);
         if (ram_w_we2) begin
            chk_eq("floor_wr_addr", ram_w_a2, wr2);
            wr2++;
         end
         prev2 = ram_if_oe2;
         dp_done2 = vec_valid2;
         @(negedge clk);
      end
      dp_done2 = 1'b0;
      chk_eq("floor_epochs", k, N_EPOCH2);
      chk_eq("floor_writes", wr2, 2);
      chk_eq("floor_done", done2, 1);
      chk_eq("floor_busy", busy2, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
